// File: rtl/rv_index_arbiter_pkg.sv
// Shared defaults and helpers for the tagged request arbiter.
// Default sizing matches the common 4-requester, 8-tag configuration.
package rv_index_arbiter_pkg;

    localparam int NUM_REQS_DEF = 4;
    localparam int DATAW_DEF    = 32;
    localparam int SIZE_DEF     = 8;
    localparam int TAGW         = $clog2(SIZE_DEF);
    localparam int IDW          = $clog2(NUM_REQS_DEF);

    // Base bit offset of lane i in a flattened bus of w-bit lanes.
    function automatic int flat_idx(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/rv_index_arbiter_rr.sv
// Round-robin arbiter: picks the first request at or after the pointer, wrapping.
// The pointer advances past the winner only when the caller confirms the grant.
module rv_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_oh_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          grant_valid_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_sel;
    logic          valid_sel;
    int            idx;

    // Scan offsets from high to low so the smallest offset from the pointer wins.
    always_comb begin
        idx_sel   = '0;
        valid_sel = 1'b0;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (req_i[idx]) begin
                idx_sel   = IW'(idx);
                valid_sel = 1'b1;
            end
        end
    end

    always_comb begin
        grant_oh_o = '0;
        if (valid_sel) grant_oh_o[idx_sel] = 1'b1;
    end

    assign grant_idx_o   = idx_sel;
    assign grant_valid_o = valid_sel;
    assign ptr_d         = (int'(idx_sel) == N - 1) ? '0 : idx_sel + IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rv_index_arbiter.sv
// Shares one tagged memory port among NUM_REQS requesters, allocating a tag per
// request and steering each response back to its owner through a tag->ID table.
module rv_index_arbiter #(
    parameter int NUM_REQS = rv_index_arbiter_pkg::NUM_REQS_DEF,
    parameter int DATAW    = rv_index_arbiter_pkg::DATAW_DEF,
    parameter int SIZE     = rv_index_arbiter_pkg::SIZE_DEF,
    parameter int TAGW     = $clog2(SIZE),
    parameter int IDW      = $clog2(NUM_REQS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      mem_req_valid,
    output logic [DATAW-1:0]          mem_req_data,
    output logic [TAGW-1:0]           mem_req_tag,
    input  logic                      mem_req_ready,
    input  logic                      mem_rsp_valid,
    input  logic [TAGW-1:0]           mem_rsp_tag,
    input  logic [DATAW-1:0]          mem_rsp_data,
    output logic                      mem_rsp_ready,
    output logic [NUM_REQS-1:0]       rsp_valid,
    output logic [DATAW-1:0]          rsp_data,
    input  logic [NUM_REQS-1:0]       rsp_ready,
    output logic [TAGW:0]             pending,
    output logic                      full,
    output logic                      empty
);
    import rv_index_arbiter_pkg::flat_idx;

    logic [SIZE-1:0]     free_q, free_d;
    logic [IDW-1:0]      id_table [SIZE];
    logic                mem_req_valid_q;
    logic [DATAW-1:0]    mem_req_data_q;
    logic [TAGW-1:0]     mem_req_tag_q;
    logic                rsp_valid_q;
    logic [IDW-1:0]      rsp_id_q;
    logic [DATAW-1:0]    rsp_data_q;
    logic [TAGW:0]       pending_q, pending_d;

    logic [NUM_REQS-1:0] arb_oh;
    logic [IDW-1:0]      arb_idx;
    logic                arb_valid;
    logic                stage_load, any_free, grant_fire, rsp_accept;
    logic [TAGW-1:0]     alloc_tag;
    logic [DATAW-1:0]    win_data;
    logic [IDW-1:0]      rsp_id;

    assign stage_load = ~mem_req_valid_q | mem_req_ready;
    assign any_free   = |free_q;
    assign grant_fire = arb_valid & stage_load & any_free;

    rv_rr_arbiter #(
        .N  (NUM_REQS),
        .IW (IDW)
    ) u_rr (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req_valid),
        .en_i          (grant_fire),
        .grant_oh_o    (arb_oh),
        .grant_idx_o   (arb_idx),
        .grant_valid_o (arb_valid)
    );

    // Lowest-indexed free tag; a tag released this cycle is not visible until the next.
    always_comb begin
        alloc_tag = '0;
        for (int t = SIZE - 1; t >= 0; t--) begin
            if (free_q[t]) alloc_tag = TAGW'(t);
        end
    end

    assign win_data      = req_data[flat_idx(int'(arb_idx), DATAW) +: DATAW];
    assign rsp_id        = id_table[mem_rsp_tag];
    assign mem_rsp_ready = ~rsp_valid_q | rsp_ready[rsp_id_q];
    assign rsp_accept    = mem_rsp_valid & mem_rsp_ready;

    always_comb begin
        free_d = free_q;
        if (grant_fire) free_d[alloc_tag]   = 1'b0;
        if (rsp_accept) free_d[mem_rsp_tag] = 1'b1;
    end

    always_comb begin
        case ({grant_fire, rsp_accept})
            2'b10:   pending_d = pending_q + {{TAGW{1'b0}}, 1'b1};
            2'b01:   pending_d = pending_q - {{TAGW{1'b0}}, 1'b1};
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            free_q          <= '1;
            mem_req_valid_q <= 1'b0;
            mem_req_data_q  <= '0;
            mem_req_tag_q   <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_data_q      <= '0;
            pending_q       <= '0;
        end else begin
            free_q    <= free_d;
            pending_q <= pending_d;
            if (grant_fire) begin
                mem_req_valid_q <= 1'b1;
                mem_req_data_q  <= win_data;
                mem_req_tag_q   <= alloc_tag;
            end else if (mem_req_ready) begin
                mem_req_valid_q <= 1'b0;
            end
            if (rsp_accept) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= rsp_id;
                rsp_data_q  <= mem_rsp_data;
            end else if (rsp_ready[rsp_id_q]) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // Owner table is write-only on grant and never needs clearing.
    always_ff @(posedge clk) begin
        if (grant_fire) id_table[alloc_tag] <= arb_idx;
    end

    // A response must name a tag that is currently allocated.
    always_ff @(posedge clk) begin
        if (!reset && rsp_accept) assert (!free_q[mem_rsp_tag]);
    end

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_lane
            assign req_ready[gi] = grant_fire & arb_oh[gi];
            assign rsp_valid[gi] = rsp_valid_q & (rsp_id_q == IDW'(gi));
        end
    endgenerate

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_data  = mem_req_data_q;
    assign mem_req_tag   = mem_req_tag_q;
    assign rsp_data      = rsp_data_q;
    assign pending       = pending_q;
    assign full          = (pending_q == (TAGW + 1)'(SIZE));
    assign empty         = (pending_q == '0);

endmodule

// File: tb/tb_rv_index_arbiter.sv
// Scoreboarded bench for rv_index_arbiter: a tag-pool reference model predicts
// grants and responses, and a separate monitor checks every output handshake.
module tb_rv_index_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SZ = 8;
    localparam int TW = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              mem_req_valid;
    logic [DW-1:0]     mem_req_data;
    logic [TW-1:0]     mem_req_tag;
    logic              mem_req_ready = 1'b0;
    logic              mem_rsp_valid = 1'b0;
    logic [TW-1:0]     mem_rsp_tag = '0;
    logic [DW-1:0]     mem_rsp_data = '0;
    logic              mem_rsp_ready;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [N-1:0]      rsp_ready = '0;
    logic [TW:0]       pending;
    logic              full;
    logic              empty;

    rv_index_arbiter #(.NUM_REQS(N), .DATAW(DW), .SIZE(SZ)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_data(mem_req_data),
        .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .pending(pending), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct { int tag; logic [DW-1:0] data; } req_exp_t;
    typedef struct { int id;  logic [DW-1:0] data; } rsp_exp_t;
    req_exp_t req_q[$];
    rsp_exp_t rsp_q[$];
    int       issued[$];

    // Reference model: tag pool, owners, fairness pointer and the two staging slots.
    bit            m_free [SZ];
    int            m_owner [SZ];
    int            m_ptr, m_pending;
    bit            m_req_staged, m_rsp_staged;
    int            m_stage_tag, m_rsp_id;
    logic [DW-1:0] m_stage_data, m_rsp_data;
    bit            rsp_taken;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < SZ; t++) m_free[t] = 1'b1;
        m_ptr = 0; m_pending = 0;
        m_req_staged = 1'b0; m_rsp_staged = 1'b0;
        m_stage_tag = 0; m_rsp_id = 0;
        m_stage_data = '0; m_rsp_data = '0;
        req_q.delete(); rsp_q.delete(); issued.delete();
        rsp_taken = 1'b0;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic step();
        int winner, tag;
        bit grant, accept, stage_load, any_free, exp_mrr;
        logic [N-1:0] exp_ready, exp_rv;
        @(negedge clk);
        rsp_taken = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            check("mem_req_valid", mem_req_valid, m_req_staged);
            if (m_req_staged) begin
                check("mem_req_tag_hold", mem_req_tag, m_stage_tag);
                check("mem_req_data_hold", mem_req_data, m_stage_data);
            end
            check("pending", pending, m_pending);
            check("full", full, m_pending == SZ);
            check("empty", empty, m_pending == 0);
            exp_rv = '0;
            if (m_rsp_staged) begin
                exp_rv[m_rsp_id] = 1'b1;
                check("rsp_data_hold", rsp_data, m_rsp_data);
            end
            check("rsp_valid", rsp_valid, exp_rv);

            stage_load = !m_req_staged || mem_req_ready;
            any_free = 1'b0;
            for (int t = 0; t < SZ; t++) if (m_free[t]) any_free = 1'b1;
            winner = -1;
            for (int k = 0; k < N; k++)
                if (winner < 0 && req_valid[(m_ptr + k) % N]) winner = (m_ptr + k) % N;
            grant = stage_load && any_free && (winner >= 0);
            exp_ready = '0;
            if (grant) exp_ready[winner] = 1'b1;
            check("req_ready", req_ready, exp_ready);

            exp_mrr = !m_rsp_staged || rsp_ready[m_rsp_id];
            check("mem_rsp_ready", mem_rsp_ready, exp_mrr);
            accept = mem_rsp_valid && exp_mrr;

            if (m_req_staged && mem_req_ready) begin
                issued.push_back(m_stage_tag);
                m_req_staged = 1'b0;
            end
            if (grant) begin
                tag = -1;
                for (int t = 0; t < SZ; t++) if (tag < 0 && m_free[t]) tag = t;
                m_free[tag] = 1'b0;
                m_owner[tag] = winner;
                m_req_staged = 1'b1;
                m_stage_tag = tag;
                m_stage_data = req_data[winner*DW +: DW];
                req_q.push_back('{tag: tag, data: m_stage_data});
                m_ptr = (winner + 1) % N;
                m_pending++;
            end
            if (m_rsp_staged && rsp_ready[m_rsp_id]) m_rsp_staged = 1'b0;
            if (accept) begin
                tag = int'(mem_rsp_tag);
                m_free[tag] = 1'b1;
                m_pending--;
                m_rsp_staged = 1'b1;
                m_rsp_id = m_owner[tag];
                m_rsp_data = mem_rsp_data;
                rsp_q.push_back('{id: m_rsp_id, data: mem_rsp_data});
                for (int i = issued.size() - 1; i >= 0; i--)
                    if (issued[i] == tag) issued.delete(i);
                rsp_taken = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req_data();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
    endtask

    // Monitor: compares every handshake on the two output channels with the scoreboard.
    initial begin
        req_exp_t re;
        rsp_exp_t se;
        int id;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_req_valid && mem_req_ready) begin
                    if (req_q.size() == 0) begin
                        check("mem_req_unexpected", 64'd1, 64'd0);
                    end else begin
                        re = req_q.pop_front();
                        check("mem_req_tag", mem_req_tag, re.tag);
                        check("mem_req_data", mem_req_data, re.data);
                    end
                end
                if ((rsp_valid & rsp_ready) != '0) begin
                    id = 0;
                    for (int i = 0; i < N; i++) if (rsp_valid[i]) id = i;
                    if (rsp_q.size() == 0) begin
                        check("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        se = rsp_q.pop_front();
                        check("rsp_id", id, se.id);
                        check("rsp_data", rsp_data, se.data);
                    end
                end
            end
        end
    end

    task automatic send_rsp(input int tag);
        mem_rsp_valid = 1'b1;
        mem_rsp_tag = TW'(tag);
        mem_rsp_data = $urandom;
        step();
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        step(); step();
        reset = 1'b0;
        check("reset_mem_req_data", mem_req_data, 0);
        check("reset_mem_req_tag", mem_req_tag, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_empty", empty, 1);

        // Fill all tags with every requester asking.
        req_valid = '1; mem_req_ready = 1'b1; rsp_ready = '1;
        for (int c = 0; c < 10; c++) begin rand_req_data(); step(); end
        check("full_after_fill", full, 1);

        // Release tag 5 from full; it must be reused only on the following cycle.
        send_rsp(5);
        for (int c = 0; c < 3; c++) begin rand_req_data(); step(); end
        check("pending_refill", pending, SZ);

        // Free two tags, then stall the request port with a request staged.
        send_rsp(1);
        send_rsp(2);
        step();
        mem_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin rand_req_data(); step(); end
        mem_req_ready = 1'b1;
        step();

        // Randomised traffic with back-pressure on both sides.
        for (int c = 0; c < 3000; c++) begin
            req_valid = N'($urandom);
            rand_req_data();
            mem_req_ready = ($urandom_range(0, 99) < 70);
            for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(0, 99) < 75);
            if (rsp_taken) mem_rsp_valid = 1'b0;
            if (!mem_rsp_valid && issued.size() > 0 && $urandom_range(0, 99) < 60) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_tag = TW'(issued[$urandom_range(0, issued.size() - 1)]);
                mem_rsp_data = $urandom;
            end
            step();
        end

        // Reset mid-operation, then the first grant must start again at tag 0.
        mem_req_ready = 1'b0; rsp_ready = '0; req_valid = '1;
        if (rsp_taken) mem_rsp_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin rand_req_data(); step(); end
        reset = 1'b1; mem_rsp_valid = 1'b0;
        step();
        reset = 1'b0; req_valid = 4'b0100; mem_req_ready = 1'b1; rsp_ready = '1;
        rand_req_data();
        step();
        req_valid = '0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
